water_level_encoder: RTL and testbench



---
 rtl/water_level_encoder.sv | 117 +++++++++++
 tb/tb_water_level_encoder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/water_level_encoder.sv
// water_level_encoder: synchronises, debounces and encodes three float switches into a 2-bit level; `define WATER_LEVEL_FAULT_LATCH_EN for a sticky sensor_fault
module water_level_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_low,
    input  logic       sensor_mid,
    input  logic       sensor_high,
    input  logic       fault_clear,
    output logic [1:0] level,
    output logic       level_valid,
    output logic       level_changed,
    output logic       sensor_fault
);
    typedef enum logic [1:0] {INIT, STABLE, SETTLING} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    state_t state, state_n;
    logic [2:0] sync1, s, cand, acc, acc_n;
    logic [1:0] fill, code, level_n;
    logic [CNT_W-1:0] cnt;
    logic cand_ok, held, accept, settle_back, cons, valid_n, fault_n, changed_n;
    function automatic logic is_cons(input logic [2:0] p);
        return p == 3'b000 || p == 3'b001 || p == 3'b011 || p == 3'b111;
    endfunction
    assign held = cand_ok && s == cand && cnt == CNT_MAX;
    assign accept = held && (state == INIT || cand != acc);
    assign settle_back = held && state == SETTLING && cand == acc;
    assign acc_n = accept ? cand : acc;
    assign cons = is_cons(cand);
    assign code = {cand[1], cand[2] | (cand[0] & ~cand[1])};
`ifndef WATER_LEVEL_FAULT_LATCH_EN
    logic unused_fault_clear;
    assign unused_fault_clear = fault_clear;
`endif
    // Two-flop synchroniser; fill marks when s holds a real sample rather than reset contents
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            s <= '0;
            fill <= '0;
        end else begin
            sync1 <= {sensor_high, sensor_mid, sensor_low};
            s <= sync1;
            fill <= {fill[0], 1'b1};
        end
    end
    // Candidate pattern and saturating stability counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_ok <= 1'b0;
            cand <= '0;
            cnt <= '0;
        end else if (fill[1]) begin
            if (!cand_ok || s != cand) begin
                cand_ok <= 1'b1;
                cand <= s;
                cnt <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
    // Next state and next output values; accept takes priority over settling
    always_comb begin
        state_n = state;
        level_n = level;
        valid_n = level_valid;
        fault_n = sensor_fault;
        changed_n = 1'b0;
        if (accept) begin
            state_n = STABLE;
            if (cons) begin
                level_n = code;
                changed_n = code != level || state == INIT;
`ifdef WATER_LEVEL_FAULT_LATCH_EN
                valid_n = !sensor_fault;
`else
                valid_n = 1'b1;
                fault_n = 1'b0;
`endif
            end else begin
                valid_n = 1'b0;
                fault_n = 1'b1;
            end
        end else if (state == STABLE && s != acc) begin
            state_n = SETTLING;
        end else if (settle_back) begin
            state_n = STABLE;
        end
`ifdef WATER_LEVEL_FAULT_LATCH_EN
        if (fault_clear && sensor_fault && !(accept && !cons)) begin
            fault_n = 1'b0;
            valid_n = is_cons(acc_n);
        end
`endif
    end
    // State, accepted pattern and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            acc <= '0;
            level <= '0;
            level_valid <= 1'b0;
            level_changed <= 1'b0;
            sensor_fault <= 1'b0;
        end else begin
            state <= state_n;
            acc <= acc_n;
            level <= level_n;
            level_valid <= valid_n;
            level_changed <= changed_n;
            sensor_fault <= fault_n;
        end
    end
endmodule

// File: tb/tb_water_level_encoder.sv
// tb_water_level_encoder: directed vectors and timing sequences for water_level_encoder at DEBOUNCE_CYCLES=4
module tb_water_level_encoder;
`ifdef WATER_LEVEL_FAULT_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, fault_clear = 1'b0;
    logic [2:0] sens = 3'b000;
    logic [1:0] level;
    logic level_valid, level_changed, sensor_fault;
    int checks = 0, failures = 0;
    typedef struct {
        logic [2:0] sens;
        int cycles;
        logic [1:0] lvl;
        logic vld;
        logic flt;
        int pulses;
    } vec_t;
    vec_t vecs[7];
    water_level_encoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .sensor_low(sens[0]),
        .sensor_mid(sens[1]),
        .sensor_high(sens[2]),
        .fault_clear(fault_clear),
        .level(level),
        .level_valid(level_valid),
        .level_changed(level_changed),
        .sensor_fault(sensor_fault)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic outs(input string name, input int lvl, input int vld, input int chg, input int flt);
        chk({name, " level"}, level, lvl);
        chk({name, " level_valid"}, level_valid, vld);
        chk({name, " level_changed"}, level_changed, chg);
        chk({name, " sensor_fault"}, sensor_fault, flt);
    endtask
    task automatic hold(input logic [2:0] p, input int n, output int pulses);
        sens = p;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            pulses += int'(level_changed);
        end
    endtask
    initial begin
        int p;
        vecs[0] = '{3'b101, 8, 2'b01, 1'b0, 1'b1, 0};
        vecs[1] = '{3'b111, 8, 2'b11, !LATCH, LATCH, 1};
        vecs[2] = '{3'b011, 8, 2'b10, !LATCH, LATCH, 1};
        vecs[3] = '{3'b000, 3, 2'b10, !LATCH, LATCH, 0};
        vecs[4] = '{3'b000, 8, 2'b00, !LATCH, LATCH, 1};
        vecs[5] = '{3'b110, 8, 2'b00, 1'b0, 1'b1, 0};
        vecs[6] = '{3'b000, 8, 2'b00, !LATCH, LATCH, 0};
        tick();
        tick();
        outs("reset", 0, 0, 0, 0);
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e < 7) chk($sformatf("init e%0d valid", e), level_valid, 0);
            if (e < 7) chk($sformatf("init e%0d changed", e), level_changed, 0);
            if (e == 7) outs("init accept", 0, 1, 1, 0);
            if (e == 8) chk("init pulse end", level_changed, 0);
        end
        sens = 3'b011;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk($sformatf("step e%0d valid", e), level_valid, 1);
            if (e < 7) chk($sformatf("step e%0d level", e), level, 0);
            if (e == 7) outs("step accept", 2, 1, 1, 0);
            if (e == 8) chk("step pulse end", level_changed, 0);
        end
        for (int t = 0; t < 10; t++) begin
            sens[1] = ~sens[1];
            for (int k = 0; k < 2; k++) begin
                tick();
                chk($sformatf("bounce t%0d level", t), level, 2);
                chk($sformatf("bounce t%0d changed", t), level_changed, 0);
            end
        end
        sens = 3'b001;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) outs("bounce e6", 2, 1, 0, 0);
            if (e == 7) outs("bounce accept", 1, 1, 1, 0);
        end
        tick();
        for (int i = 0; i < 7; i++) begin
            hold(vecs[i].sens, vecs[i].cycles, p);
            chk($sformatf("vec%0d level", i), level, vecs[i].lvl);
            chk($sformatf("vec%0d valid", i), level_valid, vecs[i].vld);
            chk($sformatf("vec%0d fault", i), sensor_fault, vecs[i].flt);
            chk($sformatf("vec%0d pulses", i), p, vecs[i].pulses);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hold(3'b111, 8, p);
        outs("pre-settle", 3, 1, 0, 0);
        hold(3'b011, 5, p);
        chk("settle no update", level, 3);
        reset = 1'b1;
        tick();
        outs("settle reset", 0, 0, 0, 0);
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 7) chk($sformatf("rst e%0d valid", e), level_valid, 0);
            if (e == 7) outs("rst accept", 2, 1, 1, 0);
        end
        hold(3'b101, 8, p);
        outs("fault set", 2, 0, 0, 1);
        hold(3'b111, 8, p);
        chk("fault recover pulses", p, 1);
        outs("fault recover", 3, !LATCH, 0, LATCH);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        outs("clear consistent", 3, 1, 0, 0);
        hold(3'b101, 8, p);
        outs("fault again", 3, 0, 0, 1);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        outs("clear inconsistent", 3, 0, 0, !LATCH);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
